// File: rtl/tc_sram_native_ctrl.sv
// tc_sram_native_ctrl: bridges the core's native valid/ready memory bus onto a
// single-port synchronous SRAM (one tc_sram_1024x32) and absorbs its 1-cycle
// read latency. Writes complete in 2 cycles, reads in 3.
// Optional power-on self-test is compiled in with `define TC_SRAM_BIST_EN.
module tc_sram_native_ctrl #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          mem_valid_i,
    output logic          mem_ready_o,
    input  logic [31:0]   mem_addr_i,
    input  logic [31:0]   mem_wdata_i,
    input  logic [3:0]    mem_wstrb_i,
    output logic [31:0]   mem_rdata_o,
    output logic          sram_cs_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_data_o,
    output logic [3:0]    sram_mask_o,
    output logic          sram_wren_o,
    input  logic [31:0]   sram_data_i,
    output logic          bist_done_o,
    output logic          bist_fail_o
);

    if (DEPTH != 2 ** AW) begin : g_depth_chk
        $error("tc_sram_native_ctrl: DEPTH must equal 2**AW");
    end

`ifdef TC_SRAM_BIST_EN
    typedef enum logic [2:0] {IDLE, CAPT, ACK, BIST_WR, BIST_RD} state_t;
    localparam state_t RESET_STATE = BIST_WR;
`else
    typedef enum logic [1:0] {IDLE, CAPT, ACK} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t      state_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};

`ifdef TC_SRAM_BIST_EN
    // Bit AW of the counter marks the extra compare-only cycle after the last read.
    logic [AW:0]   bist_cnt_q;
    logic          bist_rd_vld_q;
    logic [AW-1:0] bist_exp_idx_q;
    logic          bist_done_q;
    logic          bist_fail_q;

    function automatic logic [31:0] bist_word(input logic [AW-1:0] idx);
        return 32'hA5A5_0000 | 32'(idx);
    endfunction
`endif

    // SRAM strobes: decoded from the current state and request, forced low in reset.
    always_comb begin
        sram_cs_o   = 1'b0;
        sram_addr_o = '0;
        sram_data_o = '0;
        sram_mask_o = '0;
        sram_wren_o = 1'b0;
        if (rst_n_i) begin
            case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        sram_cs_o   = 1'b1;
                        sram_addr_o = mem_addr_i[AW+1:2];
                        sram_data_o = mem_wdata_i;
                        sram_mask_o = mem_wstrb_i;
                        sram_wren_o = |mem_wstrb_i;
                    end
                end
`ifdef TC_SRAM_BIST_EN
                BIST_WR: begin
                    sram_cs_o   = 1'b1;
                    sram_addr_o = bist_cnt_q[AW-1:0];
                    sram_data_o = bist_word(bist_cnt_q[AW-1:0]);
                    sram_mask_o = 4'hF;
                    sram_wren_o = 1'b1;
                end
                BIST_RD: begin
                    if (!bist_cnt_q[AW]) begin
                        sram_cs_o   = 1'b1;
                        sram_addr_o = bist_cnt_q[AW-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Control FSM, read-data capture and registered ready strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= RESET_STATE;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
`ifdef TC_SRAM_BIST_EN
            bist_cnt_q     <= '0;
            bist_rd_vld_q  <= 1'b0;
            bist_exp_idx_q <= '0;
            bist_done_q    <= 1'b0;
            bist_fail_q    <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        if (|mem_wstrb_i) begin
                            state_q <= ACK;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= CAPT;
                        end
                    end
                end
                CAPT: begin
                    rdata_q <= sram_data_i;
                    state_q <= ACK;
                    ready_q <= 1'b1;
                end
                ACK: begin
                    state_q <= IDLE;
                end
`ifdef TC_SRAM_BIST_EN
                BIST_WR: begin
                    if (bist_cnt_q == (AW+1)'(DEPTH - 1)) begin
                        bist_cnt_q <= '0;
                        state_q    <= BIST_RD;
                    end else begin
                        bist_cnt_q <= bist_cnt_q + (AW+1)'(1);
                    end
                end
                BIST_RD: begin
                    if (bist_cnt_q[AW]) begin
                        bist_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        bist_cnt_q <= bist_cnt_q + (AW+1)'(1);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
`ifdef TC_SRAM_BIST_EN
            // Compare each BIST read one cycle after it was issued.
            bist_rd_vld_q  <= (state_q == BIST_RD) && !bist_cnt_q[AW];
            bist_exp_idx_q <= bist_cnt_q[AW-1:0];
            if (bist_rd_vld_q && (sram_data_i != bist_word(bist_exp_idx_q))) begin
                bist_fail_q <= 1'b1;
            end
`endif
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;

`ifdef TC_SRAM_BIST_EN
    assign bist_done_o = bist_done_q;
    assign bist_fail_o = bist_fail_q;
`else
    assign bist_done_o = 1'b1;
    assign bist_fail_o = 1'b0;
`endif

endmodule
